// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: grants one outstanding bus transaction at a time to the
// fetch or data requester, with fixed data-side priority.  Rev 1.0
`default_nettype none

module mem_bus_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic        i_flush,
  output logic [31:0] i_rdata,
  output logic        i_valid,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata,
  output logic        icache_stall,
  output logic        mem_stall
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_I_ADDR = 3'd1,
    S_I_DATA = 3'd2,
    S_D_ADDR = 3'd3,
    S_D_DATA = 3'd4
  } state_t;

  localparam logic [1:0] C_SIZE_WORD = 2'b10;

  state_t      state_q, state_d;
  logic        flush_q, flush_d;
  logic        bus_req_q, bus_req_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  always_comb begin
    state_d   = state_q;
    flush_d   = flush_q;
    bus_req_d = 1'b0;
    wr_d      = wr_q;
    size_d    = size_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (d_req) begin
          state_d   = S_D_ADDR;
          bus_req_d = 1'b1;
          wr_d      = d_wr;
          size_d    = d_size;
          addr_d    = d_addr;
          wdata_d   = d_wdata;
        end else if (i_req) begin
          state_d   = S_I_ADDR;
          bus_req_d = 1'b1;
          flush_d   = 1'b0;
          wr_d      = 1'b0;
          size_d    = C_SIZE_WORD;
          addr_d    = i_addr;
          wdata_d   = 32'd0;
        end
      end
      S_I_ADDR: begin
        if (i_flush) flush_d = 1'b1;
        if (bus_addr_ok) state_d = S_I_DATA;
        else             bus_req_d = 1'b1;
      end
      S_I_DATA: begin
        // A flush here still lets the bus beat finish; only the result is dropped.
        if (i_flush) flush_d = 1'b1;
        if (bus_data_ok) state_d = S_IDLE;
      end
      S_D_ADDR: begin
        if (bus_addr_ok) state_d = S_D_DATA;
        else             bus_req_d = 1'b1;
      end
      S_D_DATA: begin
        if (bus_data_ok) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      flush_q   <= 1'b0;
      bus_req_q <= 1'b0;
      wr_q      <= 1'b0;
      size_q    <= 2'b00;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      flush_q   <= flush_d;
      bus_req_q <= bus_req_d;
      wr_q      <= wr_d;
      size_q    <= size_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign bus_req      = bus_req_q;
  assign bus_wr       = wr_q;
  assign bus_size     = size_q;
  assign bus_addr     = addr_q;
  assign bus_wdata    = wdata_q;

  assign i_valid      = (state_q == S_I_DATA) && bus_data_ok && !flush_q;
  assign d_valid      = (state_q == S_D_DATA) && bus_data_ok;
  assign i_rdata      = i_valid ? bus_rdata : 32'd0;
  assign d_rdata      = d_valid ? bus_rdata : 32'd0;
  assign icache_stall = i_req && !i_valid;
  assign mem_stall    = d_req && !d_valid;

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed scenarios with literal spot checks plus a
// transaction-level model compared against the DUT every cycle.
`default_nettype none

module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, i_flush, d_req, d_wr;
  logic [31:0] i_addr, d_addr, d_wdata, bus_rdata;
  logic [1:0]  d_size;
  logic        bus_addr_ok, bus_data_ok;
  logic [31:0] i_rdata, d_rdata, bus_addr, bus_wdata;
  logic        i_valid, d_valid, bus_req, bus_wr, icache_stall, mem_stall;
  logic [1:0]  bus_size;

  int n_chk  = 0;
  int n_fail = 0;

  mem_bus_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush),
    .i_rdata(i_rdata), .i_valid(i_valid),
    .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
    .bus_rdata(bus_rdata), .icache_stall(icache_stall), .mem_stall(mem_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Transaction-level reference: who owns the bus, whether the address phase
  // has been accepted, and the request fields captured at grant time.
  bit          m_busy, m_isd, m_acc, m_drop;
  logic        m_wr;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata;

  always @(negedge clk) begin
    bit e_iv, e_dv;
    if (!rst_n) begin
      m_busy = 0; m_isd = 0; m_acc = 0; m_drop = 0;
      m_wr = 0; m_size = 0; m_addr = 0; m_wdata = 0;
    end
    e_iv = m_busy && !m_isd && m_acc && bus_data_ok && !m_drop;
    e_dv = m_busy &&  m_isd && m_acc && bus_data_ok;
    chk("m_bus_req",   bus_req,      m_busy && !m_acc);
    chk("m_bus_wr",    bus_wr,       m_wr);
    chk("m_bus_size",  bus_size,     m_size);
    chk("m_bus_addr",  bus_addr,     m_addr);
    chk("m_bus_wdata", bus_wdata,    m_wdata);
    chk("m_i_valid",   i_valid,      e_iv);
    chk("m_d_valid",   d_valid,      e_dv);
    chk("m_i_rdata",   i_rdata,      e_iv ? bus_rdata : 32'd0);
    chk("m_d_rdata",   d_rdata,      e_dv ? bus_rdata : 32'd0);
    chk("m_istall",    icache_stall, i_req && !e_iv);
    chk("m_mstall",    mem_stall,    d_req && !e_dv);
    if (rst_n) begin
      if (!m_busy) begin
        if (d_req) begin
          m_busy = 1; m_isd = 1; m_acc = 0;
          m_wr = d_wr; m_size = d_size; m_addr = d_addr; m_wdata = d_wdata;
        end else if (i_req) begin
          m_busy = 1; m_isd = 0; m_acc = 0; m_drop = 0;
          m_wr = 0; m_size = 2'b10; m_addr = i_addr; m_wdata = 0;
        end
      end else begin
        if (!m_isd && i_flush) m_drop = 1;
        if (!m_acc) m_acc = bus_addr_ok;
        else if (bus_data_ok) begin m_busy = 0; m_acc = 0; end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic bus_idle();
    bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 32'd0;
  endtask

  initial begin
    rst_n = 0; i_req = 0; i_flush = 0; i_addr = 0;
    d_req = 0; d_wr = 0; d_size = 0; d_addr = 0; d_wdata = 0;
    bus_idle();
    tick(); #1;
    chk("rst_bus_req", bus_req, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_valids", {i_valid, d_valid}, 0);
    tick(); i_req = 1; d_req = 1; bus_data_ok = 1; #1;
    chk("rst_stalls", {icache_stall, mem_stall}, 2'b11);
    chk("rst_dvalid", d_valid, 0);
    tick(); i_req = 0; d_req = 0; bus_data_ok = 0;
    tick(); rst_n = 1;
    tick();

    // Single fetch at minimum latency
    tick(); i_req = 1; i_addr = 32'hBFC00000; #1;
    chk("f_c0_stall", icache_stall, 1);
    tick(); bus_addr_ok = 1; #1;
    chk("f_c1_bus_req", bus_req, 1);
    chk("f_c1_addr", bus_addr, 32'hBFC00000);
    chk("f_c1_size", bus_size, 2'b10);
    chk("f_c1_stall", icache_stall, 1);
    tick(); bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h3C1D0000; #1;
    chk("f_c2_valid", i_valid, 1);
    chk("f_c2_rdata", i_rdata, 32'h3C1D0000);
    chk("f_c2_stall", icache_stall, 0);
    tick(); i_req = 0; bus_idle(); #1;
    chk("f_c3_bus_req", bus_req, 0);

    // Simultaneous requests: data side first
    tick(); i_req = 1; i_addr = 32'h00400000;
    d_req = 1; d_wr = 0; d_size = 2'b10; d_addr = 32'h80001000; d_wdata = 32'h0;
    tick(); bus_addr_ok = 1; #1;
    chk("p_d_addr", bus_addr, 32'h80001000);
    chk("p_d_req", bus_req, 1);
    tick(); bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'hDEADBEEF; #1;
    chk("p_d_valid", d_valid, 1);
    chk("p_d_rdata", d_rdata, 32'hDEADBEEF);
    chk("p_stalls", {mem_stall, icache_stall}, 2'b01);
    tick(); d_req = 0; bus_idle(); #1;
    chk("p_idle_bus_req", bus_req, 0);
    tick(); bus_addr_ok = 1; #1;
    chk("p_i_addr", bus_addr, 32'h00400000);
    tick(); bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h12345678; #1;
    chk("p_i_rdata", i_rdata, 32'h12345678);
    tick(); i_req = 0; bus_idle();

    // Data request arrives while fetch is in its data phase
    tick(); i_req = 1; i_addr = 32'h00400010;
    tick(); bus_addr_ok = 1;
    tick(); bus_addr_ok = 0; d_req = 1; d_addr = 32'h80002000; d_wr = 0; #1;
    chk("w_addr_held", bus_addr, 32'h00400010);
    chk("w_mstall", mem_stall, 1);
    tick(); bus_data_ok = 1; bus_rdata = 32'h11112222; #1;
    chk("w_i_valid", i_valid, 1);
    chk("w_addr_held2", bus_addr, 32'h00400010);
    tick(); i_req = 0; bus_idle(); #1;
    chk("w_idle", bus_req, 0);
    tick(); bus_addr_ok = 1; #1;
    chk("w_d_addr", bus_addr, 32'h80002000);
    tick(); bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h55; #1;
    chk("w_d_valid", d_valid, 1);
    tick(); d_req = 0; bus_idle();

    // Byte store with three cycles of address back-pressure
    tick(); d_req = 1; d_wr = 1; d_size = 2'b00; d_addr = 32'h80003003; d_wdata = 32'hA5;
    for (int k = 0; k < 4; k++) begin
      tick(); bus_addr_ok = (k == 3); bus_data_ok = (k == 1); #1;
      chk("s_req", bus_req, 1);
      chk("s_fields", {bus_wr, bus_size}, 3'b100);
      chk("s_addr", bus_addr, 32'h80003003);
      chk("s_wdata", bus_wdata, 32'hA5);
      chk("s_no_early_valid", d_valid, 0);
    end
    tick(); bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h0; #1;
    chk("s_d_valid", d_valid, 1);
    chk("s_d_rdata", d_rdata, 0);
    tick(); d_req = 0; d_wr = 0; bus_idle();

    // Flush during the address phase
    tick(); i_req = 1; i_addr = 32'h00400020;
    tick(); i_flush = 1;
    tick(); i_flush = 0; bus_addr_ok = 1;
    tick(); bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h99; #1;
    chk("x_no_valid", i_valid, 0);
    chk("x_rdata", i_rdata, 0);
    chk("x_stall", icache_stall, 1);
    tick(); bus_idle(); i_addr = 32'h00400040; #1;
    chk("x_idle", bus_req, 0);
    tick(); bus_addr_ok = 1; #1;
    chk("x_next_addr", bus_addr, 32'h00400040);
    tick(); bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h77; #1;
    chk("x_next_valid", i_valid, 1);
    tick(); i_req = 0; bus_idle();

    // Reset pulse during the data phase
    tick(); d_req = 1; d_addr = 32'h80004000; d_size = 2'b10;
    tick(); bus_addr_ok = 1;
    tick(); bus_addr_ok = 0; rst_n = 0; #1;
    chk("r_bus_req", bus_req, 0);
    chk("r_bus_addr", bus_addr, 0);
    chk("r_mstall", mem_stall, 1);
    tick(); rst_n = 1; #1;
    chk("r_idle", bus_req, 0);
    tick(); bus_addr_ok = 1; #1;
    chk("r_regrant", bus_addr, 32'h80004000);
    tick(); bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h4444; #1;
    chk("r_d_rdata", d_rdata, 32'h4444);
    tick(); d_req = 0; bus_idle();
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
